shift_div_pow2_seq: RTL and testbench

//   Sequential power-of-two divider feeding the Shift_2 datapath family.

---
 rtl/shift_div_pow2_seq.sv | 127 ++++++++++++
 tb/tb_shift_div_pow2_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_div_pow2_seq.sv
// Sequential power-of-two divider: shifts the operand right one bit per clock
// for k' = min(in_shift, WIDTH) clocks, returning floor quotient and remainder.
module shift_div_pow2_seq #(
  parameter int WIDTH  = 16,
  parameter int CNT_W  = 5,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_clamped,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             clamped_q, clamped_d;
  logic             valid_q, valid_d;

  logic             clamp_s;
  logic [CNT_W-1:0] k_eff_s;
  logic [WIDTH-1:0] rem_load_s;
  logic             fill_s;

  // Operand preparation: clamp the count and mask off the low k' bits as remainder.
  always_comb begin
    clamp_s    = (in_shift > CNT_W'(WIDTH));
    k_eff_s    = clamp_s ? CNT_W'(WIDTH) : in_shift;
    // A shift by WIDTH yields all zeros, so the mask becomes all ones in the clamp case.
    rem_load_s = in_data & ~({WIDTH{1'b1}} << k_eff_s);
    fill_s     = (SIGNED != 0) ? quot_q[WIDTH-1] : 1'b0;
  end

  // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    clamped_d = clamped_q;
    valid_d   = valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          quot_d    = in_data;
          rem_d     = rem_load_s;
          clamped_d = clamp_s;
          count_d   = k_eff_s;
          if (k_eff_s == {CNT_W{1'b0}}) begin
            state_d = DONE;
            valid_d = 1'b1;
          end else begin
            state_d = SHIFT;
            valid_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      SHIFT: begin
        quot_d  = {fill_s, quot_q[WIDTH-1:1]};
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = DONE;
          valid_d = 1'b1;
        end else begin
          state_d = SHIFT;
          valid_d = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = DONE;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= {CNT_W{1'b0}};
      quot_q    <= {WIDTH{1'b0}};
      rem_q     <= {WIDTH{1'b0}};
      clamped_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      clamped_q <= clamped_d;
      valid_q   <= valid_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = valid_q;
  assign out_quot    = quot_q;
  assign out_rem     = rem_q;
  assign out_clamped = clamped_q;

endmodule

// File: tb/tb_shift_div_pow2_seq.sv
// Bench for shift_div_pow2_seq: an unsigned and a signed instance share stimulus
// and are checked against a floor-division reference model.
module tb_shift_div_pow2_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic [4:0]  in_shift = 5'd0;
  logic        out_ready = 1'b0;

  logic        uir, uv, ucl, ub;
  logic [15:0] uq, ur;
  logic        sir, sv, scl, sb;
  logic [15:0] sq, sr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_div_pow2_seq #(.WIDTH(16), .CNT_W(5), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(uir), .in_data(in_data),
    .in_shift(in_shift), .out_valid(uv), .out_ready(out_ready), .out_quot(uq),
    .out_rem(ur), .out_clamped(ucl), .busy(ub));

  shift_div_pow2_seq #(.WIDTH(16), .CNT_W(5), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sir), .in_data(in_data),
    .in_shift(in_shift), .out_valid(sv), .out_ready(out_ready), .out_quot(sq),
    .out_rem(sr), .out_clamped(scl), .busy(sb));

  // Reference: floor division by 2^k' with a non-negative remainder.
  function automatic void model(input logic [15:0] d, input int k, input bit sgn,
                                output logic [15:0] q, output logic [15:0] r);
    int     kp;
    longint p, x, qq, rr;
    kp = (k > 16) ? 16 : k;
    p  = longint'(1) << kp;
    x  = sgn ? longint'($signed(d)) : longint'(d);
    qq = x / p;
    if ((x % p != 0) && (x < 0)) qq = qq - 1;
    rr = x - qq * p;
    q  = qq[15:0];
    r  = rr[15:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_results(input string tag, input logic [15:0] d, input int k);
    logic [15:0] eq_u, er_u, eq_s, er_s;
    logic        ecl;
    model(d, k, 1'b0, eq_u, er_u);
    model(d, k, 1'b1, eq_s, er_s);
    ecl = (k > 16);
    n_checks++;
    if (uq !== eq_u || ur !== er_u) begin
      n_fail++;
      $display("FAIL %s unsigned q/r got %h/%h want %h/%h", tag, uq, ur, eq_u, er_u);
    end
    n_checks++;
    if (sq !== eq_s || sr !== er_s) begin
      n_fail++;
      $display("FAIL %s signed q/r got %h/%h want %h/%h", tag, sq, sr, eq_s, er_s);
    end
    n_checks++;
    if (ucl !== ecl || scl !== ecl) begin
      n_fail++;
      $display("FAIL %s clamped got %b/%b want %b", tag, ucl, scl, ecl);
    end
  endtask

  // One operation: accept, count latency, hold in DONE, then handshake.
  task automatic run_op(input string tag, input logic [15:0] d, input int k,
                        input int hold, input bit offer);
    int kp;
    int c;
    kp = (k > 16) ? 16 : k;
    n_checks++;
    if (uir !== 1'b1 || sir !== 1'b1 || ub !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle-before-accept in_ready=%b busy=%b want 1/0", tag, uir, ub);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_shift = 5'(k);
    step();
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_shift = 5'($urandom);
    c = 0;
    while (uv !== 1'b1 && c < 40) begin
      n_checks++;
      if (ub !== 1'b1 || uir !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy-in-shift busy=%b in_ready=%b want 1/0", tag, ub, uir);
      end
      step();
      c++;
    end
    n_checks++;
    if (c !== kp || sv !== 1'b1) begin
      n_fail++;
      $display("FAIL %s latency got %0d want %0d", tag, c, kp);
    end
    check_results(tag, d, k);
    for (int h = 0; h < hold; h++) begin
      if (offer) begin
        in_valid = 1'b1;
        in_data  = 16'($urandom);
        in_shift = 5'($urandom);
      end
      step();
      n_checks++;
      if (uv !== 1'b1 || uir !== 1'b0 || ub !== 1'b1) begin
        n_fail++;
        $display("FAIL %s hold valid=%b in_ready=%b busy=%b want 1/0/1", tag, uv, uir, ub);
      end
      check_results({tag, "-hold"}, d, k);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (uv !== 1'b0 || sv !== 1'b0 || uir !== 1'b1 || ub !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after-handshake valid=%b in_ready=%b busy=%b want 0/1/0", tag, uv, uir, ub);
    end
    in_valid = 1'b0;
    check_results({tag, "-kept"}, d, k);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++;
    if (uv !== 1'b0 || uq !== 16'h0000 || ur !== 16'h0000 || ucl !== 1'b0 ||
        ub !== 1'b0 || uir !== 1'b1 || sv !== 1'b0 || sq !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset valid=%b q=%h r=%h cl=%b busy=%b rdy=%b want 0/0000/0000/0/0/1",
               uv, uq, ur, ucl, ub, uir);
    end
  endtask

  task automatic test_vectors();
    run_op("v1_aaaa_k1", 16'hAAAA, 1, 0, 1'b0);
    n_checks++;
    if (uq !== 16'h5555 || ur !== 16'h0000) begin
      n_fail++;
      $display("FAIL v1 const got %h/%h want 5555/0000", uq, ur);
    end
    run_op("v2_f0f7_k4", 16'hF0F7, 4, 1, 1'b0);
    n_checks++;
    if (uq !== 16'h0F0F || ur !== 16'h0007) begin
      n_fail++;
      $display("FAIL v2 const got %h/%h want 0f0f/0007", uq, ur);
    end
    run_op("v3_0f0f_k0", 16'h0F0F, 0, 0, 1'b0);
    run_op("v4_1234_k20", 16'h1234, 20, 0, 1'b0);
    n_checks++;
    if (uq !== 16'h0000 || ur !== 16'h1234 || ucl !== 1'b1) begin
      n_fail++;
      $display("FAIL v4 const got %h/%h/%b want 0000/1234/1", uq, ur, ucl);
    end
    run_op("v5_fff9_k1", 16'hFFF9, 1, 0, 1'b0);
    n_checks++;
    if (sq !== 16'hFFFC || sr !== 16'h0001) begin
      n_fail++;
      $display("FAIL v5 signed const got %h/%h want fffc/0001", sq, sr);
    end
    run_op("v_k16", 16'h8001, 16, 0, 1'b0);
    run_op("v_k17", 16'h8001, 17, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_op("random", 16'($urandom), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 3)), 1'($urandom));
    end
  endtask

  task automatic test_hold_no_accept();
    run_op("hold5_offer", 16'h9C3B, 3, 5, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    int k, kp, c;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      d  = 16'($urandom);
      k  = int'($urandom_range(0, 6));
      kp = k;
      in_valid = 1'b1;
      in_data  = d;
      in_shift = 5'(k);
      step();
      in_data  = 16'($urandom);
      in_shift = 5'($urandom);
      c = 0;
      while (uv !== 1'b1 && c < 40) begin
        step();
        c++;
      end
      n_checks++;
      if (c !== kp) begin
        n_fail++;
        $display("FAIL b2b latency got %0d want %0d", c, kp);
      end
      check_results("b2b", d, k);
      step();
      n_checks++;
      if (uv !== 1'b0 || uir !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b throughput valid=%b in_ready=%b want 0/1", uv, uir);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_abort();
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    in_shift = 5'd12;
    step();
    in_valid = 1'b0;
    step();
    step();
    n_checks++;
    if (ub !== 1'b1) begin
      n_fail++;
      $display("FAIL abort pre-reset busy got %b want 1", ub);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (uv !== 1'b0 || ub !== 1'b0 || uir !== 1'b1 || uq !== 16'h0000 || sb !== 1'b0) begin
      n_fail++;
      $display("FAIL abort reset valid=%b busy=%b rdy=%b q=%h want 0/0/1/0000", uv, ub, uir, uq);
    end
    for (int i = 0; i < 15; i++) step();
    n_checks++;
    if (uv !== 1'b0 || sv !== 1'b0) begin
      n_fail++;
      $display("FAIL abort no-result valid=%b/%b want 0/0", uv, sv);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold_no_accept();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
